stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer.
- Selection is by internal arbitration instead of an external sel input: round-robin or fixed-priority, chosen per cycle by a mode input.
- Each input channel has a valid/ready handshake; the output is a single registered valid/ready stream carrying data and source channel index.
- Used wherever several producers share one consumer path.

Parameters:
- N_CH, 4, number of input channels (>= 2)
- WIDTH, 8, data width per channel (>= 1)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous active-high reset
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_valid  input  N_CH  per-channel valid
- in_data  input  N_CH*WIDTH  flattened data; channel i at [i*WIDTH +: WIDTH]
- in_ready  output  N_CH  per-channel ready, one-hot or zero
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_ch  output  $clog2(N_CH)  registered source channel index
- out_ready  input  1  consumer accepts beat

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_ch=0, rr_ptr=0 (channel 0 highest priority); in_ready=0 while rst is high.
- Internal state: one output register (out_valid/out_data/out_ch) and rr_ptr ($clog2(N_CH) bits).
- can_load = !out_valid || out_ready.
- Grant, combinational, among channels with in_valid=1:
  - mode=0: first requesting channel searching rr_ptr, rr_ptr+1, ... wrapping modulo N_CH.
  - mode=1: lowest requesting index; rr_ptr is ignored for selection.
- in_ready[g] = can_load for the granted channel g; all other bits are 0. in_ready is 0 for every channel when none requests.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Drain without refill (out_valid && out_ready, no input transfer): out_valid <= 0. out_data and out_ch hold their old values.
- Simultaneous drain and load in the same cycle: new beat replaces old. Full throughput is 1 beat/cycle.
- Stall (out_valid=1, out_ready=0): output register frozen, all in_ready=0. Inputs must hold valid/data (AXI-style rule, not checked).
- rr_ptr update: on any transfer, rr_ptr <= (g+1) mod N_CH, wrapping N_CH-1 -> 0. This applies in both modes, so switching mode causes no pointer jump. Without a transfer, rr_ptr holds.
- Mode may change on any cycle and takes effect for that cycle's grant. It never affects a beat already in the output register.
- Fairness, mode=0: with all channels continuously valid and out_ready=1, grant order is 0,1,...,N_CH-1,0,...
- Reset asserted mid-transfer: beat in the output register is discarded; out_valid falls immediately (async).
- Non-power-of-two N_CH: rr_ptr must never take values >= N_CH.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN
- When defined:
  - Extra input in_last [N_CH] marks the final beat of a packet.
  - Once channel g transfers a beat with in_last[g]=0, the grant is locked to g regardless of mode or other requests, until a beat with in_last[g]=1 transfers.
  - Extra output out_last is registered alongside out_data; reset value 0.
  - rr_ptr advances only on the last beat.
  - The lock flag resets to 0.
- When undefined: in_last and out_last do not exist; arbitration is per beat as above.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, all in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout; remains so after release.
- Single channel, N_CH=4, WIDTH=8, mode=0: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=8'hA5, out_ch=2; rr_ptr=3.
- Round-robin fairness: in_valid=4'b1111 held, data = channel index, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle from the second cycle.
- Fixed priority: mode=1, in_valid=4'b1010 held 3 cycles -> out_ch=1 every beat; switch to mode=0 with rr_ptr=2 -> next grant ch3.
- Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 4 cycles with in_valid=4'b0001 -> in_ready=0, out_data stays 8'h3C; on out_ready=1, ch0 beat loads next edge.
- Async reset mid-stream: during the fairness test, assert rst between edges -> out_valid drops immediately; after release the first grant is ch0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input, WIDTH-bit stream multiplexer with internal
// arbitration. mode=0 selects round-robin starting at rr_ptr, mode=1 selects
// the lowest requesting index. The output is a single registered valid/ready
// stage carrying data and the source channel index.
//
// Optional feature (macro STREAM_MUX_PKT_LOCK_EN): adds in_last/out_last and
// locks the grant to a channel from its first non-last beat until its last
// beat transfers. With the macro undefined arbitration is per beat.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CW-1:0]         out_ch,
    input  logic                  out_ready
);

    // Channel count and last index at the width of the wrap arithmetic.
    localparam logic [CW:0]   N_CH_W   = (CW+1)'(N_CH);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_CH - 1);

    // Output register and round-robin pointer.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CW-1:0]    out_ch_q,    out_ch_d;
    logic [CW-1:0]    rr_ptr_q,    rr_ptr_d;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             out_last_q, out_last_d;
    logic             lock_q,     lock_d;
    logic [CW-1:0]    lock_ch_q,  lock_ch_d;
`endif

    // Arbitration results.
    logic             rr_found_s;
    logic [CW-1:0]    rr_idx_s;
    logic             fp_found_s;
    logic [CW-1:0]    fp_idx_s;
    logic             grant_found_s;
    logic [CW-1:0]    grant_idx_s;
    logic             can_load_s;
    logic             xfer_s;
    logic [CW:0]      cand_s;
    logic [CW-1:0]    ptr_next_s;

    // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        cand_s     = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand_s = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (cand_s >= N_CH_W) begin
                cand_s = cand_s - N_CH_W;
            end else begin
                cand_s = cand_s;
            end
            if (!rr_found_s && in_valid[cand_s[CW-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s[CW-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Fixed-priority search: lowest requesting index.
    always_comb begin
        fp_found_s = 1'b0;
        fp_idx_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!fp_found_s && in_valid[i]) begin
                fp_found_s = 1'b1;
                fp_idx_s   = CW'(i);
            end else begin
                fp_found_s = fp_found_s;
            end
        end
    end

    // Final grant: mode select, overridden by an active packet lock.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            grant_found_s = in_valid[lock_ch_q];
            grant_idx_s   = lock_ch_q;
        end else if (mode) begin
            grant_found_s = fp_found_s;
            grant_idx_s   = fp_idx_s;
        end else begin
            grant_found_s = rr_found_s;
            grant_idx_s   = rr_idx_s;
        end
`else
        if (mode) begin
            grant_found_s = fp_found_s;
            grant_idx_s   = fp_idx_s;
        end else begin
            grant_found_s = rr_found_s;
            grant_idx_s   = rr_idx_s;
        end
`endif
    end

    // Handshake: the granted channel is ready whenever the output stage can load.
    always_comb begin
        can_load_s = !out_valid_q || out_ready;
        xfer_s     = grant_found_s && can_load_s && !rst;
        in_ready   = '0;
        if (xfer_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state for the output register, pointer and packet lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        ptr_next_s  = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + CW'(1);
`ifdef STREAM_MUX_PKT_LOCK_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx_s*WIDTH +: WIDTH];
            out_ch_d    = grant_idx_s;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_d  = in_last[grant_idx_s];
            if (in_last[grant_idx_s]) begin
                lock_d   = 1'b0;
                rr_ptr_d = ptr_next_s;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx_s;
            end
`else
            rr_ptr_d    = ptr_next_s;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (default build): directed scenarios
// followed by randomized traffic, all compared against a transaction-level
// reference model of the arbiter and output stage.
module tb_stream_mux_rr;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    bit m_ov;
    int m_od;
    int m_och;
    int m_ptr;

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Which channel the spec's rules grant, or -1 when nobody requests.
    function automatic int ref_grant(input logic [N-1:0] v, input logic m, input int ptr);
        if (m) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = ref_grant(in_valid, mode, m_ptr);
        if (!rst && g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_od = 0; m_och = 0; m_ptr = 0;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] d);
        in_data[c*W +: W] = d;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        int g;
        bit cl;
        #1;
        chk("in_ready", in_ready, ref_ready());
        g  = ref_grant(in_valid, mode, m_ptr);
        cl = !m_ov || out_ready;
        @(posedge clk);
        if (g >= 0 && cl) begin
            m_ov = 1'b1; m_od = in_data[g*W +: W]; m_och = g; m_ptr = (g + 1) % N;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_ch", out_ch, m_och);
    endtask

    // Assert reset between edges and confirm the output clears immediately.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("async_ov", out_valid, 0);
        chk("async_data", out_data, 0);
        chk("async_rdy", in_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        model_reset();

        // Reset then idle.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ov", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_ch", out_ch, 0);
            chk("rst_rdy", in_ready, 0);
        end
        rst = 1'b0;
        repeat (2) cycle();
        chk("idle_ov", out_valid, 0);

        // Round-robin fairness with every channel requesting.
        in_valid = 4'b1111;
        for (int c = 0; c < N; c++) set_ch(c, W'(c));
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_ch", out_ch, i % 4);
            chk("rr_ov", out_valid, 1);
        end

        // Async reset mid-stream; first grant after release is ch0.
        async_reset();
        cycle();
        chk("rst_first_ch", out_ch, 0);

        // Single channel request.
        in_valid = 4'b0100;
        set_ch(2, 8'hA5);
        #1;
        chk("single_rdy", in_ready, 4'b0100);
        cycle();
        chk("single_data", out_data, 8'hA5);
        chk("single_ch", out_ch, 2);

        // Fixed priority, then back to round-robin from rr_ptr=2.
        mode = 1'b1;
        in_valid = 4'b1010;
        repeat (3) begin
            cycle();
            chk("fp_ch", out_ch, 1);
        end
        mode = 1'b0;
        cycle();
        chk("rr_after_fp", out_ch, 3);

        // Backpressure: drain, load 3C, stall 4 cycles, then release.
        in_valid = '0;
        cycle();
        in_valid = 4'b0001;
        set_ch(0, 8'h3C);
        out_ready = 1'b0;
        cycle();
        chk("bp_load", out_data, 8'h3C);
        repeat (4) begin
            cycle();
            chk("bp_rdy", in_ready, 0);
            chk("bp_data", out_data, 8'h3C);
        end
        set_ch(0, 8'h5A);
        out_ready = 1'b1;
        cycle();
        chk("bp_release_data", out_data, 8'h5A);
        chk("bp_release_ch", out_ch, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            mode      = 1'($urandom_range(0, 1));
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
